// File: rtl/reg_bank_reader_pkg.sv
// Shared CPU register-bank package: bank geometry and the read-port state type.
package reg_bank_reader_pkg;

  localparam int CPU_DATA_W   = 4;
  localparam int CPU_ADDR_W   = 2;
  localparam int CPU_NUM_REGS = 2 ** CPU_ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } reader_state_t;

endpackage

// File: rtl/reg_bank_reader_if.sv
// Request and output-stream signals of the register-bank read port.
// Optional macro READER_PARITY_EN adds the dout_par signal.
interface reg_bank_reader_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
);

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rd_len;
  logic              rd_busy;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              rd_done;
  logic              rd_err;
`ifdef READER_PARITY_EN
  logic              dout_par;
`endif

  // Requester / consumer side.
  modport master (
    output rd_req, rd_addr, rd_len, dout_ready,
`ifdef READER_PARITY_EN
    input  dout_par,
`endif
    input  rd_busy, dout, dout_valid, rd_done, rd_err
  );

  // Reader side.
  modport slave (
    input  rd_req, rd_addr, rd_len, dout_ready,
`ifdef READER_PARITY_EN
    output dout_par,
`endif
    output rd_busy, dout, dout_valid, rd_done, rd_err
  );

endinterface

// File: rtl/reg_word_mux.sv
// Combinational word selector from a flattened register bank.
module reg_word_mux #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 2
) (
  input  logic [NUM_REGS*DATA_W-1:0] i_regs_q,
  input  logic [ADDR_W-1:0]          i_addr,
  output logic [DATA_W-1:0]          o_word
);

  // Pick the slice belonging to the addressed register.
  always_comb begin
    o_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_addr == ADDR_W'(i)) begin
        o_word = i_regs_q[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/reg_bank_reader.sv
// Burst read port for the enable-load register bank: snapshots one word per
// FETCH and presents it on a valid/ready stream.
// Optional macro READER_PARITY_EN adds the even-parity output dout_par.
module reg_bank_reader
  import reg_bank_reader_pkg::*;
#(
  parameter int NUM_REGS = CPU_NUM_REGS,
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REGS*DATA_W-1:0] regs_q,
  reg_bank_reader_if.slave           bus
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(NUM_REGS);

  reader_state_t     r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remaining;
  logic [DATA_W-1:0] r_dout;
  logic              r_valid;
  logic              r_done;
  logic              r_err;
  logic [DATA_W-1:0] w_word;
`ifdef READER_PARITY_EN
  logic              r_par;
`endif

  reg_word_mux #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_word_mux (
    .i_regs_q (regs_q),
    .i_addr   (r_addr),
    .o_word   (w_word)
  );

  // Read FSM with its counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef READER_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.rd_req) begin
            if (bus.rd_len != '0 && bus.rd_len <= LEN_MAX) begin
              r_addr      <= bus.rd_addr;
              r_remaining <= bus.rd_len;
              r_state     <= FETCH;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        FETCH: begin
          r_dout  <= w_word;
          r_valid <= 1'b1;
`ifdef READER_PARITY_EN
          r_par   <= ^w_word;
`endif
          r_state <= PRESENT;
        end
        PRESENT: begin
          if (r_valid && bus.dout_ready) begin
            r_valid <= 1'b0;
            if (r_remaining == (ADDR_W + 1)'(1)) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              // Address wraps naturally because NUM_REGS == 2**ADDR_W.
              r_remaining <= r_remaining - 1'b1;
              r_addr      <= r_addr + 1'b1;
              r_state     <= FETCH;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Busy is decoded from state; everything else comes straight from registers.
  assign bus.rd_busy    = (r_state != IDLE);
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.rd_done    = r_done;
  assign bus.rd_err     = r_err;
`ifdef READER_PARITY_EN
  assign bus.dout_par   = r_par;
`endif

endmodule

// File: doc/reg_bank_reader.md
# reg_bank_reader

Read port for the CPU's bank of 4-bit enable-load registers. The registers are write-only from the datapath side. This block is the matching read side. It accepts a read request for a start address and burst length. It snapshots each selected register's Q into an output holding register and presents the words one at a time on a valid/ready stream to the ALU/bus side.

## Interface
Parameters:
- NUM_REGS, 4, number of registers in the bank; must equal 2**ADDR_W
- DATA_W, 4, register width
- ADDR_W, 2, register address width

Ports:
- clk  input  1  system clock; all state updates on posedge clk
- reset  input  1  synchronous, active-high reset
- regs_q  input  NUM_REGS*DATA_W  concatenated register Q outputs; register i occupies bits [i*DATA_W +: DATA_W]
- rd_req  input  1  read request; sampled only in IDLE
- rd_addr  input  ADDR_W  start address, sampled with rd_req
- rd_len  input  ADDR_W+1  burst length, 1..NUM_REGS, sampled with rd_req
- rd_busy  output  1  high whenever state is not IDLE
- dout  output  DATA_W  snapshot of the current register word
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout when high with dout_valid
- rd_done  output  1  one-cycle pulse after the last word of a burst is consumed
- rd_err  output  1  one-cycle pulse when a request is rejected

## Operation
- Reset value of every output is 0. All outputs are registered except rd_busy, which decodes from state. State resets to IDLE.
- States are IDLE, FETCH and PRESENT.
- IDLE:
  - rd_req=1 with 1 <= rd_len <= NUM_REGS: latch cur_addr=rd_addr and remaining=rd_len, then go to FETCH.
  - rd_req=1 with rd_len=0 or rd_len>NUM_REGS: pulse rd_err next cycle and stay in IDLE.
- FETCH: at the edge, dout <= regs_q slice at cur_addr and dout_valid <= 1, then go to PRESENT.
- PRESENT: hold dout and dout_valid stable until dout_valid & dout_ready at an edge.
  - If remaining==1: dout_valid <= 0, rd_done <= 1 for one cycle, go to IDLE.
  - Otherwise: remaining--, cur_addr <= cur_addr+1 modulo NUM_REGS (wraps from NUM_REGS-1 to 0), go to FETCH.
- Snapshot semantics: register writes after the FETCH edge do not alter a presented dout.
- rd_req while busy is ignored, not queued.
- dout keeps its last value after a burst ends; only dout_valid qualifies it.

## Timing
- Request accepted at edge N: rd_busy is high from cycle N+1, and dout_valid rises after edge N+1.
- Each word takes one FETCH cycle plus at least one PRESENT cycle. Peak throughput is one word per 2 cycles.
- rd_done is high for exactly the cycle after the final handshake edge. rd_busy is low in that same cycle.
- A new request may be accepted in the same cycle rd_done is high (state is IDLE).
- Reset mid-burst: at the next edge, state goes to IDLE and all outputs go to 0. No rd_done is issued and the burst is abandoned.
- reset and rd_req asserted together: reset wins.

## Configuration
- READER_PARITY_EN defined:
  - Adds output port dout_par (1 bit), the even parity of the word (XOR of all dout bits).
  - It is registered in the same FETCH edge as dout, and its reset value is 0.
- READER_PARITY_EN undefined: the dout_par port and its logic are absent, and behaviour is otherwise identical.

## Structure
- The shared CPU package holds:
  - DATA_W and the register-count constants.
  - The reader state typedef (IDLE/FETCH/PRESENT).
- One sub-module is natural: reg_word_mux, a combinational selector from regs_q by address, reusable by other read ports.
- The FSM, counters and output registers stay in reg_bank_reader.

## Test plan
- Single read: regs_q={4'hD,4'hC,4'hB,4'hA}, req addr=1 len=1, ready held 1 -> dout=4'hB valid after 2nd edge, rd_done pulse 1 cycle later, rd_busy then 0.
- Wrap burst: addr=3 len=3, ready=1 -> words 4'hD, 4'hA, 4'hB in order, each valid for one cycle with one FETCH gap, single rd_done.
- Backpressure/snapshot: addr=0 len=1, ready=0 for 5 cycles while reg0 changes 4'hA->4'h5 -> dout stays 4'hA and valid stays 1, consumed when ready=1.
- Errors and overlap: len=0 -> rd_err pulse, no busy. Len=5 -> rd_err pulse. rd_req during a burst -> ignored, no extra words.
- Reset mid-burst: addr=0 len=4, assert reset after 2nd word -> all outputs 0 next edge, no rd_done, new request then works normally.
- With READER_PARITY_EN: dout=4'hB -> dout_par=1, dout=4'hA -> dout_par=0.
